tb_tcdm_mem_model: RTL

Parametrised multi-port TCDM memory model for RedMulE testbenches. It replaces the fixed 32-bit, single-latency dummy memory with several generalisations:
- configurable data width and response latency;
- deterministic, seedable stall generation (LFSR or periodic) instead of `$random`;
- out-of-range error detection;
- exported per-port traffic counters.

It sits between the accelerator's TCDM master ports and the testbench, in place of the dummy memory.

---
 rtl/tb_tcdm_mem_pkg.sv | 17 +
 rtl/tb_tcdm_mem_model_if.sv | 17 +
 rtl/tb_tcdm_mem_stall_gen.sv | 58 +++++
 rtl/tb_tcdm_mem_model.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/tb_tcdm_mem_pkg.sv
// rtl/tb_tcdm_mem_pkg.sv - shared types and constants for the TCDM memory model
package tb_tcdm_mem_pkg;

    typedef enum logic [1:0] {
        STALL_NONE     = 2'd0,
        STALL_LFSR     = 2'd1,
        STALL_PERIODIC = 2'd2
    } stall_mode_e;

    localparam logic [15:0] LFSR_POLY   = 16'hB400;
    localparam logic [31:0] ERR_PATTERN = 32'hDEADBEEF;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/tb_tcdm_mem_model_if.sv
// rtl/tb_tcdm_mem_model_if.sv - TCDM request/response channel between accelerator and memory
interface hwpe_stream_intf_tcdm #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    req;
    logic                    gnt;
    logic [31:0]             add;
    logic                    wen;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_valid;

    modport master (output req, add, wen, be, data, input  gnt, r_data, r_valid);
    modport slave  (input  req, add, wen, be, data, output gnt, r_data, r_valid);

endinterface

// File: rtl/tb_tcdm_mem_stall_gen.sv
// rtl/tb_tcdm_mem_stall_gen.sv - per-port deterministic stall source (LFSR or periodic)
module tb_tcdm_mem_stall_gen
    import tb_tcdm_mem_pkg::*;
#(
    parameter stall_mode_e STALL_MODE   = STALL_NONE,
    parameter logic [7:0]  STALL_THRESH = 8'd0,
    parameter int unsigned STALL_PERIOD = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stallable_i,
    input  logic [15:0] seed_i,
    input  logic [31:0] port_idx_i,
    output logic        stall_o
);
    localparam int unsigned   CW   = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(STALL_PERIOD - 1);

    logic [15:0]   lfsr_q, lfsr_d, seed;
    logic [CW-1:0] cnt_q, cnt_d, slot;
    logic          stall_q, stall_d;

    // An all-zero Galois LFSR would lock up, so zero seeds become 1.
    assign seed = (seed_i == 16'd0) ? 16'd1 : seed_i;
    assign slot = CW'(port_idx_i % STALL_PERIOD);

    // stall_d is derived from the next state so stall_q lines up with the current count.
    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_POLY;
        end
        cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        stall_d = 1'b0;
        if (stallable_i) begin
            case (STALL_MODE)
                STALL_LFSR:     stall_d = (lfsr_d[7:0] < STALL_THRESH);
                STALL_PERIODIC: stall_d = (cnt_d == slot);
                default:        stall_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q  <= seed;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign stall_o = stall_q;

endmodule

// File: rtl/tb_tcdm_mem_model.sv
// rtl/tb_tcdm_mem_model.sv - multi-port TCDM memory model with latency, stalls, errors and counters
module tb_tcdm_mem_model
    import tb_tcdm_mem_pkg::*;
#(
    parameter int unsigned MP           = 1,
    parameter int unsigned DW           = 32,
    parameter int unsigned MEMORY_SIZE  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int unsigned LATENCY      = 1,
    parameter stall_mode_e STALL_MODE   = STALL_NONE,
    parameter logic [7:0]  STALL_THRESH = 8'd0,
    parameter int unsigned STALL_PERIOD = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                enable_i,
    input  logic                stallable_i,
    hwpe_stream_intf_tcdm.slave tcdm [MP-1:0],
    output logic [MP-1:0]       err_o,
    output logic [MP-1:0][31:0] cnt_rd_o,
    output logic [MP-1:0][31:0] cnt_wr_o,
    output logic [MP-1:0][31:0] cnt_stall_o
);
    localparam int unsigned   BW       = DW / 8;
    localparam int unsigned   OFFS     = $clog2(BW);
    localparam int unsigned   AW       = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
    localparam logic [DW-1:0] ERR_WORD = {(DW/32){ERR_PATTERN}};

    logic [DW-1:0] mem_q [MEMORY_SIZE];

    logic [MP-1:0]         req, wen, gnt, oor;
    logic [MP-1:0][AW-1:0] idx;
    logic [MP-1:0][BW-1:0] be;
    logic [MP-1:0][DW-1:0] wdata;

    for (genvar i = 0; i < MP; i++) begin : g_port
        logic [31:0]                off, word;
        logic [DW-1:0]              old_word, merged, resp;
        logic                       stall;
        logic [LATENCY-1:0]         vld_q;
        logic [LATENCY-1:0][DW-1:0] dat_q;
        logic [31:0]                cnt_rd_q, cnt_wr_q, cnt_st_q;
        logic                       err_q;

        assign req[i]   = tcdm[i].req;
        assign wen[i]   = tcdm[i].wen;
        assign be[i]    = tcdm[i].be;
        assign wdata[i] = tcdm[i].data;

        assign off    = tcdm[i].add - BASE_ADDR;
        assign word   = off >> OFFS;
        assign oor[i] = (tcdm[i].add < BASE_ADDR) || (word >= MEMORY_SIZE);
        assign idx[i] = word[AW-1:0];

        tb_tcdm_mem_stall_gen #(
            .STALL_MODE   (STALL_MODE),
            .STALL_THRESH (STALL_THRESH),
            .STALL_PERIOD (STALL_PERIOD)
        ) i_stall_gen (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .stallable_i (stallable_i),
            .seed_i      (LFSR_SEED ^ 16'(i)),
            .port_idx_i  (32'(i)),
            .stall_o     (stall)
        );

        assign gnt[i]   = req[i] & enable_i & ~stall;
        assign old_word = mem_q[idx[i]];

        always_comb begin
            merged = old_word;
            for (int b = 0; b < BW; b++) begin
                if (be[i][b]) begin
                    merged[8*b +: 8] = wdata[i][8*b +: 8];
                end
            end
        end

        // Reads return the pre-write word even if another port writes it this cycle.
        assign resp = oor[i] ? ERR_WORD : (wen[i] ? old_word : merged);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld_q <= '0;
                dat_q <= '0;
            end else begin
                vld_q[0] <= gnt[i];
                dat_q[0] <= gnt[i] ? resp : '0;
                for (int k = 1; k < LATENCY; k++) begin
                    vld_q[k] <= vld_q[k-1];
                    dat_q[k] <= dat_q[k-1];
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_rd_q <= '0;
                cnt_wr_q <= '0;
                cnt_st_q <= '0;
                err_q    <= 1'b0;
            end else if (clear_i) begin
                cnt_rd_q <= '0;
                cnt_wr_q <= '0;
                cnt_st_q <= '0;
                err_q    <= 1'b0;
            end else begin
                if (gnt[i] && wen[i])  cnt_rd_q <= sat_inc(cnt_rd_q);
                if (gnt[i] && !wen[i]) cnt_wr_q <= sat_inc(cnt_wr_q);
                if (req[i] && !gnt[i]) cnt_st_q <= sat_inc(cnt_st_q);
                if (gnt[i] && oor[i])  err_q    <= 1'b1;
            end
        end

        assign tcdm[i].gnt     = gnt[i];
        assign tcdm[i].r_valid = vld_q[LATENCY-1];
        assign tcdm[i].r_data  = dat_q[LATENCY-1];
        assign err_o[i]        = err_q;
        assign cnt_rd_o[i]     = cnt_rd_q;
        assign cnt_wr_o[i]     = cnt_wr_q;
        assign cnt_stall_o[i]  = cnt_st_q;
    end

    // Ports are visited in ascending order, so the last nonblocking write (highest port) wins per byte.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < MP; p++) begin
            if (gnt[p] && !wen[p] && !oor[p]) begin
                for (int b = 0; b < BW; b++) begin
                    if (be[p][b]) begin
                        mem_q[idx[p]][8*b +: 8] <= wdata[p][8*b +: 8];
                    end
                end
            end
        end
    end

endmodule
